// File: rtl/find_set_enumerator.sv
// find_set_enumerator: accepts a WIDTH-bit vector and emits the index of every set bit,
// one handshaked beat per bit, in ascending or descending order chosen per request.
`default_nettype none

module find_set_enumerator #(
  parameter int WIDTH         = 32,
  parameter     INSTANCE_NAME = "FES",
  localparam int IW           = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_msb_first,
  input  logic             i_abort,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IW-1:0]    o_index,
  output logic [IW-1:0]    o_seq,
  output logic [IW-1:0]    o_remaining,
  output logic             o_last,
  output logic             o_empty
);

  if (WIDTH < 2) begin : g_width_check
    $error("%s: WIDTH must be at least 2", INSTANCE_NAME);
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    seq_q, seq_d;

  logic [IW-1:0]    lo_idx;
  logic [IW-1:0]    hi_idx;
  logic [IW-1:0]    pop_cnt;
  logic             accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      seq_q   <= seq_d;
    end
  end

  // An empty mask leaves both finders at WIDTH, which is the empty-beat index.
  always_comb begin
    lo_idx  = IW'(WIDTH);
    hi_idx  = IW'(WIDTH);
    pop_cnt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i]) lo_idx = IW'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (mask_q[i]) hi_idx = IW'(i);
      pop_cnt = pop_cnt + IW'(mask_q[i]);
    end
  end

  assign o_valid     = (state_q == S_SCAN);
  assign o_index     = mode_q ? hi_idx : lo_idx;
  assign o_seq       = seq_q;
  assign o_remaining = pop_cnt;
  assign o_last      = (pop_cnt <= IW'(1));
  assign o_empty     = (mask_q == '0);

  // The SCAN term lets the next request load on the final beat with no bubble.
  assign o_ready = !i_rst && !i_abort &&
                   ((state_q == S_IDLE) || ((state_q == S_SCAN) && o_last && i_ready));
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    seq_d   = seq_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SCAN;
          mask_d  = i_data;
          mode_d  = i_msb_first;
          seq_d   = '0;
        end
      end
      S_SCAN: begin
        if (i_abort) begin
          state_d = S_IDLE;
          mask_d  = '0;
          seq_d   = '0;
        end else if (i_ready) begin
          if (!o_last) begin
            mask_d = mask_q & ~(WIDTH'(1) << o_index);
            seq_d  = seq_q + IW'(1);
          end else if (accept) begin
            mask_d = i_data;
            mode_d = i_msb_first;
            seq_d  = '0;
          end else begin
            state_d = S_IDLE;
            mask_d  = '0;
            seq_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_find_set_enumerator.sv
// Directed bench: cycle table on an 8-bit instance plus an all-ones run on a 32-bit instance.
`default_nettype none

module tb_find_set_enumerator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst8 = 1'b1;
  logic       valid8 = 1'b0, msb8 = 1'b0, abort8 = 1'b0, rdy8 = 1'b0;
  logic [7:0] data8 = '0;
  logic       ordy8, ov8, last8, empty8;
  logic [3:0] idx8, seq8, rem8;

  // 32-bit instance
  logic        rst32 = 1'b1;
  logic        valid32 = 1'b0, msb32 = 1'b0, abort32 = 1'b0, rdy32 = 1'b0;
  logic [31:0] data32 = '0;
  logic        ordy32, ov32, last32, empty32;
  logic [5:0]  idx32, seq32, rem32;

  int n_checks = 0;
  int n_errors = 0;

  find_set_enumerator #(.WIDTH(8), .INSTANCE_NAME("FES8")) u_dut8 (
    .i_clk(clk), .i_rst(rst8), .i_valid(valid8), .o_ready(ordy8),
    .i_data(data8), .i_msb_first(msb8), .i_abort(abort8),
    .o_valid(ov8), .i_ready(rdy8), .o_index(idx8), .o_seq(seq8),
    .o_remaining(rem8), .o_last(last8), .o_empty(empty8)
  );

  find_set_enumerator #(.WIDTH(32), .INSTANCE_NAME("FES32")) u_dut32 (
    .i_clk(clk), .i_rst(rst32), .i_valid(valid32), .o_ready(ordy32),
    .i_data(data32), .i_msb_first(msb32), .i_abort(abort32),
    .o_valid(ov32), .i_ready(rdy32), .o_index(idx32), .o_seq(seq32),
    .o_remaining(rem32), .o_last(last32), .o_empty(empty32)
  );

  typedef struct {
    logic       rst, valid;
    logic [7:0] data;
    logic       msb, abort, rdy;
    logic       ov, ordy;
    logic [3:0] idx, seq, rem;
    logic       last, empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic valid, input logic [7:0] data,
                              input logic msb, input logic abort, input logic rdy,
                              input logic ov, input logic ordy, input logic [3:0] idx,
                              input logic [3:0] seq, input logic [3:0] rem,
                              input logic last, input logic empty);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.msb = msb; v.abort = abort; v.rdy = rdy;
    v.ov = ov; v.ordy = ordy; v.idx = idx; v.seq = seq; v.rem = rem;
    v.last = last; v.empty = empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    //            rst v  data   m  ab rdy | ov rdy idx seq rem last empty
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0,   0, 0, 8, 0, 0, 1, 1)); // 0 reset
    vecs.push_back(mk(0, 1, 8'hA4, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1)); // 1 accept A4 asc
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 2, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 5, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 1, 7, 2, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'hA4, 1, 0, 1,   0, 1, 8, 0, 0, 1, 1)); // 5 accept A4 desc
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 7, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   1, 0, 5, 1, 2, 0, 0)); // 7-9 stall
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   1, 0, 5, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   1, 0, 5, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 5, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 1, 2, 2, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1)); // 12 accept empty
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 1, 8, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h81, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1)); // 14 accept 81 asc
    vecs.push_back(mk(0, 1, 8'h03, 1, 0, 1,   1, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 8'h03, 1, 0, 1,   1, 1, 7, 1, 1, 1, 0)); // 16 back-to-back accept
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1)); // 19 accept FF
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 0, 0, 8, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 1, 1, 7, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1,   1, 0, 2, 2, 6, 0, 0)); // 22 abort on beat 3
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'hF0, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1)); // 24 accept F0
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 4, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   1, 0, 5, 1, 3, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1,   0, 0, 8, 0, 0, 1, 1)); // 27 reset mid-request
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h55, 0, 1, 1,   0, 0, 8, 0, 0, 1, 1)); // 29 abort in IDLE
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 1, 8, 0, 0, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      rst8 = vecs[i].rst; valid8 = vecs[i].valid; data8 = vecs[i].data;
      msb8 = vecs[i].msb; abort8 = vecs[i].abort; rdy8 = vecs[i].rdy;
      #1;
      chk($sformatf("row%0d o_valid", i),     32'(ov8),    32'(vecs[i].ov));
      chk($sformatf("row%0d o_ready", i),     32'(ordy8),  32'(vecs[i].ordy));
      chk($sformatf("row%0d o_index", i),     32'(idx8),   32'(vecs[i].idx));
      chk($sformatf("row%0d o_seq", i),       32'(seq8),   32'(vecs[i].seq));
      chk($sformatf("row%0d o_remaining", i), 32'(rem8),   32'(vecs[i].rem));
      chk($sformatf("row%0d o_last", i),      32'(last8),  32'(vecs[i].last));
      chk($sformatf("row%0d o_empty", i),     32'(empty8), 32'(vecs[i].empty));
      @(posedge clk);
      #1;
    end

    // WIDTH=32 all-ones: 32 beats with ascending seq and descending remaining count.
    #1;
    chk("w32 reset o_valid", 32'(ov32), 32'd0);
    chk("w32 reset o_ready", 32'(ordy32), 32'd0);
    chk("w32 reset o_index", 32'(idx32), 32'd32);
    chk("w32 reset o_empty", 32'(empty32), 32'd1);
    @(posedge clk);
    #1;
    rst32 = 1'b0;
    valid32 = 1'b1; data32 = 32'hFFFF_FFFF; msb32 = 1'b0; rdy32 = 1'b1;
    #1;
    chk("w32 idle o_ready", 32'(ordy32), 32'd1);
    @(posedge clk);
    #1;
    valid32 = 1'b0; data32 = 32'h0000_0000; msb32 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk($sformatf("w32 beat%0d o_valid", k),     32'(ov32),   32'd1);
      chk($sformatf("w32 beat%0d o_index", k),     32'(idx32),  32'(k));
      chk($sformatf("w32 beat%0d o_seq", k),       32'(seq32),  32'(k));
      chk($sformatf("w32 beat%0d o_remaining", k), 32'(rem32),  32'(32 - k));
      chk($sformatf("w32 beat%0d o_last", k),      32'(last32), (k == 31) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    #1;
    chk("w32 done o_valid", 32'(ov32), 32'd0);
    chk("w32 done o_ready", 32'(ordy32), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/find_set_enumerator.md
# find_set_enumerator

Sequential successor to the combinational first-set finder. Accepts a WIDTH-bit vector over a valid/ready handshake and enumerates the index of every set bit, one per accepted output beat, in LSB-first or MSB-first order selected per request. Each beat carries ordinal, remaining-count and last flags. Used by schedulers and interrupt/grant logic that must service every pending request, not only the first.

## Interface
- WIDTH, 32, vector width; legal range WIDTH >= 2, not restricted to powers of two.
- INSTANCE_NAME, "FES", debug label only; no functional effect.
- Derived: IW = $clog2(WIDTH)+1, used for every index/count port.

- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  request accepted when i_valid & o_ready.
- i_data  input  WIDTH  vector to enumerate.
- i_msb_first  input  1  order for this request: 0 = ascending index, 1 = descending.
- i_abort  input  1  synchronous flush of the request in progress.
- o_valid  output  1  output beat valid.
- i_ready  input  1  output beat consumed when o_valid & i_ready.
- o_index  output  IW  bit index of this beat; WIDTH on an empty beat.
- o_seq  output  IW  0-based ordinal of this beat within the request.
- o_remaining  output  IW  set bits still pending, including this beat.
- o_last  output  1  final beat of the request.
- o_empty  output  1  request vector was all zeros.

## Operation
- State: mask (WIDTH), mode (1), seq (IW), FSM {IDLE, SCAN}.
- IDLE:
  - o_valid = 0.
  - On accept: mask <- i_data, mode <- i_msb_first, seq <- 0, go to SCAN.
- SCAN:
  - o_valid = 1.
  - o_index = lowest set bit of mask (mode 0) or highest set bit (mode 1).
  - o_remaining = popcount(mask).
  - o_last = (o_remaining <= 1).
  - o_empty = (mask == 0); then o_index = WIDTH, o_remaining = 0, o_last = 1.
- Beat consumed, not last: clear mask[o_index], seq <- seq+1, stay in SCAN.
- Beat consumed, last: go to IDLE, unless a new request is accepted in the same cycle (next bullet).
- o_ready = !i_rst & !i_abort & (IDLE | (SCAN & o_last & i_ready)).
  - The SCAN term allows back-to-back requests with no idle bubble.
  - A same-cycle accept reloads mask/mode/seq and stays in SCAN.
  - o_ready depends combinationally on i_ready only in that term.
- i_abort in SCAN: next state IDLE, mask <- 0, no further beats.
  - Overrides a same-cycle output handshake: the beat counts as not consumed.
  - Blocks acceptance that cycle.
- i_abort in IDLE: no effect other than forcing o_ready low.
- Output fields are combinational from registered mask/mode/seq. They are held stable while o_valid & !i_ready.
- i_data and i_msb_first are sampled only on accept. Later changes have no effect on the request in flight.

## Timing
- Reset (async assert, sync-safe release):
  - FSM = IDLE, mask = 0, mode = 0, seq = 0.
  - Outputs: o_valid = 0, o_ready = 0 while i_rst is high, o_index = WIDTH, o_seq = 0, o_remaining = 0, o_last = 1, o_empty = 1.
- Reset mid-request discards it with no further beats. o_ready = 1 on the first cycle after i_rst deasserts.
- Latency: request accepted at edge N; first beat has o_valid = 1 in cycle N+1.
- Throughput: one beat per cycle while i_ready = 1.
  - A request with k set bits occupies max(k,1) output beats.
  - Back-to-back requests take max(k,1) cycles each with no gap.
- All-ones vector: WIDTH beats, o_seq 0..WIDTH-1, o_remaining WIDTH..1.
- Index and count arithmetic is unsigned IW-bit; no wrap is possible because every value is <= WIDTH.

## Test plan
- WIDTH=8, accept 8'b1010_0100 with mode 0, i_ready=1 -> 3 beats, indices 2,5,7; o_seq 0,1,2; o_remaining 3,2,1; o_last on the third beat; first beat in the cycle after accept.
- Same vector with mode 1 -> indices 7,5,2. Hold i_ready=0 for 3 cycles on beat 2 -> o_index stays 5 and all other outputs are stable.
- Accept 8'h00 -> one beat: o_empty=1, o_index=8, o_remaining=0, o_last=1; then IDLE.
- Back-to-back 8'h81 (mode 0) then 8'h03 (mode 1), i_valid held high -> indices 0,7,1,0 on consecutive cycles; second request accepted on the last beat of the first.
- 8'hFF with i_abort asserted alongside i_ready on beat 3 -> beat 3 is not consumed, o_valid=0 next cycle, o_ready=1 the cycle after the abort.
- Assert i_rst mid-request on 8'hF0 -> immediate o_valid=0 and reset output values. Then WIDTH=32 with 32'hFFFF_FFFF -> 32 beats, o_seq ends at 31.
